// File: rtl/seg_scan_driver.sv
// Eight-digit seven-segment scan controller with a per-slot blanking gap.
// Drives a 3-to-8 decoder for the digit commons and the shared segment bus.
module seg_scan_driver #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        G1,
  output logic        G2AN,
  output logic        G2BN,
  output logic [6:0]  SEG_N,
  output logic        DP_N,
  output logic        frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [31:0] VIS = 32'(DIV - BLANK);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx;
  logic [2:0]    idx_d;
  logic [31:0]   snap;
  logic [31:0]   snap_d;
  logic [7:0]    snap_dp;
  logic [7:0]    snap_dp_d;
  logic [7:0]    snap_en;
  logic [7:0]    snap_en_d;
  logic          load;
  logic          wrap;
  logic          vis_d;
  logic [3:0]    nib_d;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    g = 7'h7F;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Outputs are computed from the post-edge position and snapshot.
  always_comb begin
    load  = 1'b0;
    wrap  = 1'b0;
    cnt_d = '0;
    idx_d = '0;
    if (state == IDLE) begin
      load = 1'b1;
    end else if (cnt == CMAX) begin
      idx_d = idx + 3'd1;
      wrap  = (idx == 3'd7);
      load  = wrap;
    end else begin
      cnt_d = cnt + 1'b1;
      idx_d = idx;
    end
    snap_d    = load ? data : snap;
    snap_dp_d = load ? dp_in : snap_dp;
    snap_en_d = load ? digit_en : snap_en;
    nib_d     = snap_d[{idx_d, 2'b00} +: 4];
    vis_d     = (32'(cnt_d) < VIS) && snap_en_d[idx_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      snap      <= '0;
      snap_dp   <= '0;
      snap_en   <= '0;
      {C, B, A} <= 3'b000;
      G1        <= 1'b0;
      G2AN      <= 1'b1;
      G2BN      <= 1'b1;
      SEG_N     <= 7'h7F;
      DP_N      <= 1'b1;
      frame     <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      {C, B, A} <= 3'b000;
      G1        <= 1'b0;
      G2AN      <= 1'b1;
      G2BN      <= 1'b1;
      SEG_N     <= 7'h7F;
      DP_N      <= 1'b1;
      frame     <= 1'b0;
    end else begin
      state     <= SCAN;
      cnt       <= cnt_d;
      idx       <= idx_d;
      snap      <= snap_d;
      snap_dp   <= snap_dp_d;
      snap_en   <= snap_en_d;
      {C, B, A} <= idx_d;
      G1        <= vis_d;
      G2AN      <= 1'b0;
      G2BN      <= 1'b0;
      SEG_N     <= vis_d ? glyph(nib_d) : 7'h7F;
      DP_N      <= ~(vis_d & snap_dp_d[idx_d]);
      frame     <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus queues expected vectors,
// a monitor pops and compares one vector per clock.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en8 = 1'b0;
  logic        en2 = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp_in = '0;

  logic a8, b8, c8, g1_8, g2a8, g2b8, dpn8, fr8;
  logic a2, b2, c2, g1_2, g2a2, g2b2, dpn2, fr2;
  logic [6:0] seg8, seg2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [14:0] q8[$];
  logic [14:0] q2[$];

  logic [31:0] sd;
  logic [7:0]  sp;
  logic [7:0]  se;

  localparam logic [14:0] IDLE_V =
    {3'b000, 1'b0, 1'b1, 1'b1, 7'h7F, 1'b1, 1'b0};

  localparam logic [6:0] GL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan_driver #(.DIV(8), .BLANK(2)) u8 (
    .clk(clk), .rst(rst), .en(en8), .data(data),
    .digit_en(digit_en), .dp_in(dp_in),
    .A(a8), .B(b8), .C(c8), .G1(g1_8), .G2AN(g2a8), .G2BN(g2b8),
    .SEG_N(seg8), .DP_N(dpn8), .frame(fr8)
  );

  seg_scan_driver #(.DIV(2), .BLANK(0)) u2 (
    .clk(clk), .rst(rst), .en(en2), .data(data),
    .digit_en(digit_en), .dp_in(dp_in),
    .A(a2), .B(b2), .C(c2), .G1(g1_2), .G2AN(g2a2), .G2BN(g2b2),
    .SEG_N(seg2), .DP_N(dpn2), .frame(fr2)
  );

  always #5 clk = ~clk;

  wire [14:0] o8 = {c8, b8, a8, g1_8, g2a8, g2b8, seg8, dpn8, fr8};
  wire [14:0] o2 = {c2, b2, a2, g1_2, g2a2, g2b2, seg2, dpn2, fr2};

  // Expected outputs t cycles after scan entry, from the slot timing rules.
  function automatic logic [14:0] expv(input int t, input int div,
                                       input int blank);
    int slot;
    int c;
    logic lit;
    logic fr;
    logic [3:0] nib;
    logic [6:0] seg;
    logic dpn;
    slot = (t / div) % 8;
    c    = t % div;
    fr   = (t > 0) && (t % (8 * div) == 0);
    lit  = (c < div - blank) && se[slot];
    nib  = sd[4*slot +: 4];
    seg  = lit ? GL[nib] : 7'h7F;
    dpn  = lit ? ~sp[slot] : 1'b1;
    return {slot[2:0], lit, 1'b0, 1'b0, seg, dpn, fr};
  endfunction

  task automatic chk(input string nm, input logic [14:0] act,
                     input logic [14:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got cba=%b g1=%b g2an=%b g2bn=%b seg=%b dpn=%b fr=%b, want cba=%b g1=%b g2an=%b g2bn=%b seg=%b dpn=%b fr=%b",
        nm, $time, act[14:12], act[11], act[10], act[9], act[8:2],
        act[1], act[0], exp[14:12], exp[11], exp[10], exp[9],
        exp[8:2], exp[1], exp[0]);
    end
  endtask

  task automatic load_model();
    sd = data;
    sp = dp_in;
    se = digit_en;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) chk("u8_scan", o8, q8.pop_front());
      if (q2.size() > 0) chk("u2_scan", o2, q2.pop_front());
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("u8_reset", o8, IDLE_V);
    chk("u2_reset", o2, IDLE_V);
    rst = 1'b0;

    @(negedge clk);
    data     = 32'h76543210;
    digit_en = 8'hFF;
    dp_in    = 8'h01;
    en8      = 1'b1;
    for (int t = 0; t <= 234; t++) begin
      if (t == 72) digit_en = 8'h0F;
      if (t == 152) begin
        data     = 32'hFFFFFFFF;
        digit_en = 8'hFF;
      end
      if (t % 64 == 0) load_model();
      q8.push_back(expv(t, 8, 2));
      @(negedge clk);
    end

    en8 = 1'b0;
    repeat (3) begin
      q8.push_back(IDLE_V);
      @(negedge clk);
    end

    data = 32'h76543210;
    en8  = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (t == 0) load_model();
      q8.push_back(expv(t, 8, 2));
      @(negedge clk);
    end

    #2 rst = 1'b1;
    #1 chk("u8_rst_async", o8, IDLE_V);
    @(negedge clk);
    chk("u8_rst_hold", o8, IDLE_V);
    en8 = 1'b0;
    rst = 1'b0;

    @(negedge clk);
    data     = 32'hFEDCBA98;
    dp_in    = 8'hA5;
    digit_en = 8'hFF;
    en2      = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (t % 16 == 0) load_model();
      q2.push_back(expv(t, 2, 0));
      @(negedge clk);
    end
    en2 = 1'b0;
    q2.push_back(IDLE_V);
    repeat (3) @(negedge clk);

    n_tests++;
    if (q8.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d/%0d left, want 0/0",
               q8.size(), q2.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
- Produces the 3-bit digit select code (C,B,A) and the three enables (G1,G2AN,G2BN) for the downstream 3-to-8 active-low decoder, whose Y0N..Y7N outputs drive the digit commons.
- Also drives the shared active-low segment bus with the hex glyph of the currently selected digit.
- Inserts a blanking interval at the end of each digit slot to suppress ghosting.

Parameters:
- DIV, 50000, clock cycles per digit slot; legal range DIV >= 2.
- BLANK, 500, cycles at the end of each slot with the decoder disabled; legal range 0 <= BLANK < DIV.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous active-high reset
- en  input  1  scan enable; 0 forces idle
- data  input  32  eight hex nibbles; data[4i+3:4i] is digit i
- digit_en  input  8  per-digit enable; 0 keeps that digit dark during its slot
- dp_in  input  8  decimal point request per digit, active-high
- A  output  1  select code bit 0 (LSB of digit index)
- B  output  1  select code bit 1
- C  output  1  select code bit 2
- G1  output  1  decoder enable, active-high
- G2AN  output  1  decoder enable, active-low
- G2BN  output  1  decoder enable, active-low
- SEG_N  output  7  segments {g,f,e,d,c,b,a}, active-low
- DP_N  output  1  decimal point, active-low
- frame  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0

Behaviour:
- Clocking and reset:
  - Every output is registered.
  - rst=1 asynchronously sets: state IDLE, cnt=0, idx=0, {C,B,A}=000, G1=0, G2AN=1, G2BN=1, SEG_N=7'h7F, DP_N=1, frame=0, snapshot=0.
- States:
  - IDLE: all outputs hold their reset values. On en=1, the next edge enters SCAN with cnt=0, idx=0 and snapshot<=data, snap_dp<=dp_in, snap_en<=digit_en.
  - SCAN: cnt counts 0..DIV-1. At cnt==DIV-1 the next edge sets cnt=0 and idx=idx+1 modulo 8. When idx wraps 7->0, the snapshot registers reload from data/dp_in/digit_en on that same edge.
  - Any edge with en=0 returns to IDLE, which restores the reset output values on that edge. Re-enabling always restarts at idx 0, cnt 0.
- Outputs in SCAN reflect the post-edge (idx,cnt):
  - {C,B,A}=idx at all times in SCAN, including blanked cycles.
  - visible = (cnt < DIV-BLANK) & snap_en[idx].
  - G1=visible. G2AN=0 and G2BN=0 throughout SCAN, so the decoder enable pattern is 100 exactly when visible.
  - When visible: SEG_N=glyph(snapshot nibble idx), DP_N=~snap_dp[idx]. Otherwise SEG_N=7'h7F and DP_N=1.
  - glyph (g..a, active-low), standard hex:
    - 0:1000000, 1:1111001, 2:0100100, 3:0110000
    - 4:0011001, 5:0010010, 6:0000010, 7:1111000
    - 8:0000000, 9:0010000, A:0001000, b:0000011
    - C:1000110, d:0100001, E:0000110, F:0001110
- frame: 1 for exactly one cycle, on the cycle in which idx=0, cnt=0 after a wrap from 7. Not asserted on the initial IDLE->SCAN entry. Period is 8*DIV cycles.
- Slot timing: each slot lasts exactly DIV cycles. The digit is lit for DIV-BLANK cycles when enabled. With BLANK=0 there is no dark gap.
- Frame coherence: changes to data, dp_in or digit_en mid-frame have no effect until the next wrap.
- cnt width is clog2(DIV); idx is 3 bits and wraps naturally.

Test Plan:
- Reset: assert rst mid-slot with en=1 -> outputs immediately (no clock) take {C,B,A}=000, G1=0, G2AN=1, G2BN=1, SEG_N=7'h7F, DP_N=1, frame=0.
- Full frame, DIV=8, BLANK=2, data=32'h76543210, digit_en=8'hFF, dp_in=8'h01:
  - idx steps 0..7, each held 8 cycles; G1 high 6 cycles, then low 2.
  - Slot 0 shows SEG_N=1000000 with DP_N=0; slot 7 shows 1111000.
  - frame pulses at cycle 64 after entry.
- Mask: digit_en=8'h0F -> in slots 4..7, G1 stays 0 and SEG_N stays 7'h7F while {C,B,A} still cycles 100..111.
- Coherence: change data to 32'hFFFFFFFF during slot 3 -> slots 3..7 keep the old glyphs; after the wrap, every slot shows 0001110.
- en drop: deassert en during slot 5, cnt=2 -> next edge gives IDLE outputs. Reassert -> scan resumes at idx 0, cnt 0, with no frame pulse on entry.
- Edge parameters: BLANK=0, DIV=2 -> G1 is continuously 1 with all digits enabled, {C,B,A} changes every 2 cycles, frame period is 16 cycles.
